// File: rtl/fetch_unit.sv
// ============================================================================
// Module  : fetch_unit
// Purpose : PC/IR fetch sequencer issuing opcode/ra/rb to decode via valid/ready.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_unit #(
  parameter int              PC_W     = 8,
  parameter int              INSTR_W  = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [3:0]         opcode,
  output logic [1:0]         ra,
  output logic [1:0]         rb,
  output logic [PC_W-1:0]    pc_out,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2
  } state_t;

  state_t             r_state;
  logic [PC_W-1:0]    r_pc;
  logic [INSTR_W-1:0] r_ir;
  logic [PC_W-1:0]    r_pc_out;
  logic               r_req;
  logic               r_valid;
  logic               r_pend;
  logic [PC_W-1:0]    r_pend_pc;
  logic               r_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_pc      <= RESET_PC;
      r_ir      <= '0;
      r_pc_out  <= '0;
      r_req     <= 1'b0;
      r_valid   <= 1'b0;
      r_pend    <= 1'b0;
      r_pend_pc <= '0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_FETCH;
            r_req   <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        S_FETCH: begin
          // Requests are never aborted: a redirect seen mid-fetch is parked
          // until the ack, then the stale data is dropped and we refetch.
          if (imem_ack) begin
            if (r_pend || redirect_valid) begin
              r_pc   <= redirect_valid ? redirect_pc : r_pend_pc;
              r_pend <= 1'b0;
            end else begin
              r_ir     <= imem_data;
              r_pc_out <= r_pc;
              r_req    <= 1'b0;
              r_valid  <= 1'b1;
              r_state  <= S_ISSUE;
            end
          end else if (redirect_valid) begin
            r_pend    <= 1'b1;
            r_pend_pc <= redirect_pc;
          end
        end
        S_ISSUE: begin
          if (redirect_valid || instr_ready) begin
            r_pc    <= redirect_valid ? redirect_pc : r_pc + 1'b1;
            r_valid <= 1'b0;
            r_req   <= 1'b1;
            r_state <= S_FETCH;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign imem_req    = r_req;
  assign imem_addr   = r_pc;
  assign instr_valid = r_valid;
  assign opcode      = r_ir[INSTR_W-1 -: 4];
  assign ra          = r_ir[3:2];
  assign rb          = r_ir[1:0];
  assign pc_out      = r_pc_out;
  assign busy        = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module  : tb_fetch_unit
// Purpose : Randomized scoreboard bench for fetch_unit with a transaction-level model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_ack = 1'b0;
  logic [7:0] imem_data = 8'h00;
  logic       instr_valid;
  logic       instr_ready = 1'b0;
  logic [3:0] opcode;
  logic [1:0] ra;
  logic [1:0] rb;
  logic [7:0] pc_out;
  logic       redirect_valid = 1'b0;
  logic [7:0] redirect_pc = 8'h00;
  logic       busy;

  logic       rst2_n = 1'b0;
  logic       start2 = 1'b0;
  logic       req2;
  logic [7:0] addr2;
  logic       ack2 = 1'b0;
  logic       valid2;
  logic       ready2 = 1'b0;
  logic [3:0] op2;
  logic [1:0] ra2;
  logic [1:0] rb2;
  logic [7:0] pcout2;
  logic       busy2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_unit #(.PC_W(8), .INSTR_W(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .ra(ra), .rb(rb), .pc_out(pc_out),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy)
  );

  fetch_unit #(.PC_W(8), .INSTR_W(8), .RESET_PC(8'hFF)) dut_wrap (
    .clk(clk), .rst_n(rst2_n), .start(start2),
    .imem_req(req2), .imem_addr(addr2), .imem_ack(ack2), .imem_data(8'hA5),
    .instr_valid(valid2), .instr_ready(ready2),
    .opcode(op2), .ra(ra2), .rb(rb2), .pc_out(pcout2),
    .redirect_valid(1'b0), .redirect_pc(8'h00), .busy(busy2)
  );

  // Reference model: program image, abstract phase, next fetch address.
  localparam int P_IDLE  = 0;
  localparam int P_FETCH = 1;
  localparam int P_ISSUE = 2;

  logic [7:0]  mem [256];
  int          phase = P_IDLE;
  logic [7:0]  exp_addr = 8'h00;
  bit          dirty = 1'b0;
  logic [7:0]  tgt = 8'h00;
  logic [15:0] sb_q [$];
  int          lat_cnt = 0;
  int          lat = 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle, entered and left at posedge+1.
  task automatic step(input int rdy_pct, input int rd_pct, input bit st);
    check("imem_req", 32'(imem_req), 32'(phase == P_FETCH));
    check("instr_valid", 32'(instr_valid), 32'(phase == P_ISSUE));
    check("busy", 32'(busy), 32'(phase != P_IDLE));
    if (phase != P_ISSUE) check("imem_addr", 32'(imem_addr), 32'(exp_addr));

    imem_ack  = 1'b0;
    imem_data = 8'($urandom);
    if (phase == P_IDLE) begin
      imem_ack = ($urandom_range(0, 3) == 0);
    end else if (imem_req) begin
      if (lat_cnt >= lat) begin
        imem_ack  = 1'b1;
        imem_data = mem[imem_addr];
        lat_cnt   = 0;
        lat       = $urandom_range(0, 3);
      end else begin
        lat_cnt++;
      end
    end
    instr_ready    = ($urandom_range(0, 99) < rdy_pct);
    redirect_valid = ($urandom_range(0, 99) < rd_pct);
    redirect_pc    = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom);
    start          = st;

    case (phase)
      P_IDLE: if (st) phase = P_FETCH;
      P_FETCH: begin
        if (redirect_valid) begin
          tgt   = redirect_pc;
          dirty = 1'b1;
        end
        if (imem_ack) begin
          if (dirty) begin
            exp_addr = tgt;
            dirty    = 1'b0;
          end else begin
            sb_q.push_back({mem[exp_addr], exp_addr});
            phase = P_ISSUE;
          end
        end
      end
      default: begin
        if (redirect_valid) begin
          exp_addr = redirect_pc;
          phase    = P_FETCH;
        end else if (instr_ready) begin
          exp_addr = exp_addr + 8'd1;
          phase    = P_FETCH;
        end
      end
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    phase    = P_IDLE;
    exp_addr = 8'h00;
    dirty    = 1'b0;
    lat_cnt  = 0;
    sb_q.delete();
  endtask

  // Monitor: pops an expected instruction whenever IR is newly presented,
  // and insists the presented instruction holds steady until the handshake.
  logic        prev_valid = 1'b0;
  logic [15:0] held = 16'h0;
  logic [15:0] exp_item;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (instr_valid && !prev_valid) begin
        if (sb_q.size() == 0) begin
          check("unexpected_issue", 32'({opcode, ra, rb, pc_out}), 32'hFFFF_FFFF);
        end else begin
          exp_item = sb_q.pop_front();
          check("issue", 32'({opcode, ra, rb, pc_out}), 32'(exp_item));
        end
        held = {opcode, ra, rb, pc_out};
      end else if (instr_valid) begin
        check("ir_stable", 32'({opcode, ra, rb, pc_out}), 32'(held));
      end
      prev_valid = instr_valid;
    end
  end

  initial begin
    bit reached;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h4B;
    mem[1] = 8'h2E;

    #2;
    check("rst_imem_req", 32'(imem_req), 32'h0);
    check("rst_valid", 32'(instr_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_pc", 32'(imem_addr), 32'h00);
    check("rst_pc_out", 32'(pc_out), 32'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();

    for (int i = 0; i < 4; i++) step(100, 0, 1'b0);
    step(100, 0, 1'b1);
    for (int i = 0; i < 12; i++) step(100, 0, 1'b0);   // stream 4B@0, 2E@1, ...
    for (int i = 0; i < 12; i++) step(0, 0, 1'b0);     // backpressure
    for (int i = 0; i < 300; i++) step(50, 20, 1'b0);  // redirects in both phases
    for (int i = 0; i < 2500; i++) step($urandom_range(10, 100), $urandom_range(0, 30), 1'b0);

    reached = 1'b0;
    for (int i = 0; i < 50 && !reached; i++) begin
      if (phase == P_FETCH) reached = 1'b1;
      else step(100, 0, 1'b0);
    end
    check("reach_fetch_timeout", 32'(reached), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_req", 32'(imem_req), 32'h0);
    check("async_rst_valid", 32'(instr_valid), 32'h0);
    check("async_rst_busy", 32'(busy), 32'h0);
    imem_ack = 1'b0;
    redirect_valid = 1'b0;
    instr_ready = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 6; i++) step(50, 30, 1'b0);     // idle ignores ack/redirect
    step(100, 0, 1'b1);
    for (int i = 0; i < 1500; i++) step($urandom_range(20, 100), $urandom_range(0, 25), 1'b0);
    imem_ack = 1'b0;
    redirect_valid = 1'b0;
    instr_ready = 1'b0;
    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(sb_q.size()), 32'h0);

    // Wrap from RESET_PC=8'hFF.
    @(posedge clk);
    #1;
    rst2_n = 1'b1;
    check("wrap_reset_addr", 32'(addr2), 32'hFF);
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    check("wrap_req", 32'(req2), 32'h1);
    check("wrap_addr_ff", 32'(addr2), 32'hFF);
    ack2 = 1'b1;
    @(posedge clk);
    #1;
    ack2 = 1'b0;
    check("wrap_valid", 32'(valid2), 32'h1);
    check("wrap_issue", 32'({op2, ra2, rb2, pcout2}), 32'h0000_A5FF);
    ready2 = 1'b1;
    @(posedge clk);
    #1;
    ready2 = 1'b0;
    check("wrap_req2", 32'(req2), 32'h1);
    check("wrap_addr_00", 32'(addr2), 32'h00);
    check("wrap_valid_drop", 32'(valid2), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
